// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters, issue stall and flush.
// Latency: stall/issue_fire are combinational; counter updates show on busy_mask one cycle later.
// Backpressure: stall holds decode while a read or write targets a register with a pending write.
//
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-low reset
//   clear          - synchronous flush of all pending counters
//   issue_*        - decoded instruction: valid, src/dst fields, read/write intent
//   use_src/use_dst- instruction reads issue_src / issue_dst as operands
//   wr_dst         - instruction will write issue_dst at writeback
//   wb_valid/wb_dst- writeback commit of a register write
//   stall          - hold decode this cycle
//   issue_fire     - instruction issues this cycle
//   busy_mask      - bit r set while register r has a pending write
//   stall_cnt      - saturating count of stalled cycles
//   underflow      - sticky: writeback seen for a register with nothing pending
module reg_scoreboard #(
  parameter int N         = 3,
  parameter int NREG      = 8,
  parameter int CW        = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            issue_valid,
  input  logic [N-1:0]    issue_src,
  input  logic [N-1:0]    issue_dst,
  input  logic            use_src,
  input  logic            use_dst,
  input  logic            wr_dst,
  input  logic            wb_valid,
  input  logic [N-1:0]    wb_dst,
  output logic            stall,
  output logic            issue_fire,
  output logic [NREG-1:0] busy_mask,
  output logic [15:0]     stall_cnt,
  output logic            underflow
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]   cnt [NREG];
  logic [CW-1:0]   src_cnt;
  logic [CW-1:0]   dst_cnt;
  logic [CW-1:0]   wb_cnt;
  logic            src_bypass;
  logic            dst_bypass;
  logic            src_pend;
  logic            dst_pend;
  logic            raw_hazard;
  logic            waw_hazard;
  logic            sat_hazard;
  logic            inc_en;
  logic            dec_en;
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;

  assign src_cnt = cnt[issue_src];
  assign dst_cnt = cnt[issue_dst];
  assign wb_cnt  = cnt[wb_dst];

  // A writeback retiring the last pending write to a register releases it
  // in the same cycle when bypass is enabled.
  assign src_bypass = WB_BYPASS && wb_valid && (wb_dst == issue_src) && (src_cnt == CNT_ONE);
  assign dst_bypass = WB_BYPASS && wb_valid && (wb_dst == issue_dst) && (dst_cnt == CNT_ONE);

  assign src_pend = (src_cnt != '0) && !src_bypass;
  assign dst_pend = (dst_cnt != '0) && !dst_bypass;

  assign raw_hazard = (use_src && src_pend) || (use_dst && dst_pend);
  assign waw_hazard = wr_dst && dst_pend;
  // Cannot trigger while WAW stalls are in force; guards the counter from wrapping.
  assign sat_hazard = wr_dst && (dst_cnt == CNT_MAX);

  assign stall      = issue_valid && (raw_hazard || waw_hazard || sat_hazard);
  assign issue_fire = issue_valid && !stall;

  assign inc_en = issue_fire && wr_dst;
  assign dec_en = wb_valid && (wb_cnt != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en) inc_vec[issue_dst] = 1'b1;
    if (dec_en) dec_vec[wb_dst]    = 1'b1;
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_mask[i] = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
      stall_cnt <= '0;
      underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (clear) begin
          cnt[i] <= '0;
        end else if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
        // inc and dec on the same register cancel out
      end

      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end

      if (wb_valid && (wb_cnt == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-hazard scoreboard for the decode stage: tracks outstanding writes to each architectural register between issue and writeback.
- Raises a stall to hold fetch/decode while an instruction reads or writes a register that still has a pending write.
- Sits beside the decode register file. It is fed by decoded src/dst fields and control-unit write intent, and by the writeback regWrite/dst pair.

Parameters:
- N, 3, register address width.
- NREG, 8, number of registers (2**N).
- CW, 2, width of per-register pending counter; max pending = 2**CW-1.
- WB_BYPASS, 1, 1 = writeback in the same cycle clears a hazard on that register; 0 = it does not.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: zero all counters.
- issue_valid  in  1  decode holds a valid instruction.
- issue_src  in  N  source register.
- issue_dst  in  N  destination register.
- use_src  in  1  instruction reads issue_src.
- use_dst  in  1  instruction reads issue_dst as an operand.
- wr_dst  in  1  instruction will write issue_dst (WB regWrite intent).
- wb_valid  in  1  writeback commits a register write this cycle.
- wb_dst  in  N  writeback destination.
- stall  out  1  hold decode; instruction not issued this cycle.
- issue_fire  out  1  issue_valid && !stall.
- busy_mask  out  NREG  bit r = counter[r] != 0 (registered view).
- stall_cnt  out  16  saturating count of stalled cycles.
- underflow  out  1  sticky error: writeback to a register with counter 0.

Behaviour:
- Reset (rst=0, async): all counters 0; busy_mask=0; stall_cnt=0; underflow=0.
- stall and issue_fire are combinational from inputs and current counters. With issue_valid=0, stall=0 and issue_fire=0.
- pend(r) = counter[r]!=0, except when WB_BYPASS=1, wb_valid=1, wb_dst==r and counter[r]==1. In that case pend(r)=0.
- RAW hazard: use_src && pend(issue_src), or use_dst && pend(issue_dst).
- WAW hazard: wr_dst && pend(issue_dst). This enforces in-order writeback to each register.
- Saturation: wr_dst && counter[issue_dst]==2**CW-1 also causes a stall. This is unreachable when WAW stalls, but is kept as a safety net.
- stall = issue_valid && (RAW || WAW || saturation).
- Counter update at the rising edge (one-cycle latency, visible in busy_mask next cycle):
  - inc = issue_fire && wr_dst, applied to issue_dst.
  - dec = wb_valid && counter[wb_dst]!=0, applied to wb_dst.
  - inc and dec on the same register: net unchanged.
  - inc and dec on different registers: both applied.
- wb_valid with counter[wb_dst]==0: no decrement; underflow<=1 (sticky until reset).
- clear=1: all counters <=0 at the edge and overrides inc/dec in that cycle. stall is still computed normally in the clear cycle. stall_cnt and underflow are not affected by clear.
- stall_cnt increments by 1 each cycle stall=1 and holds at 16'hFFFF.
- Register 0 is not special; it is tracked like any other register.
- Reset asserted mid-operation: everything returns to reset values immediately; no pending write survives.

Test Plan:
- Reset, then issue wr_dst=1, dst=R3 → issue_fire=1; next cycle busy_mask=8'b0000_1000, stall=0 when idle.
- With R3 pending, issue use_src=1, src=R3 → stall=1 each cycle. Apply wb_valid, wb_dst=3: WB_BYPASS=1 gives stall=0 that same cycle; WB_BYPASS=0 gives stall=0 the next cycle. stall_cnt equals the number of stalled cycles.
- Same-cycle issue wr_dst=1 dst=R5 and wb_valid wb_dst=R5 with counter[5]=1 → counter[5] stays 1. Separately, issue to R2 with wb to R5 → busy_mask bit2=1, bit5=0.
- R4 pending, issue wr_dst=1 dst=R4 with no reads → stall=1 (WAW) until R4 writeback.
- wb_valid wb_dst=R6 with counter 0 → underflow=1 and stays 1; counters unchanged; a later clear leaves underflow=1.
- Pend R1, R2, R7; assert clear → busy_mask=0 next cycle. Drive stall for 70000 cycles → stall_cnt=16'hFFFF. Async rst=0 mid-cycle → all outputs 0 immediately.
